// File: rtl/counter_param.sv
// Parametrised up/down modulo counter with load, wrap/saturate mode, terminal count and ovf pulse.
// Optional sticky overflow flag (i_ovf_clr / o_ovf_sticky) when COUNTER_OVF_STICKY_EN is defined.
module counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int unsigned RST_VAL  = 0,
  parameter int unsigned SATURATE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
`ifdef COUNTER_OVF_STICKY_EN
  input  logic             i_ovf_clr,
  output logic             o_ovf_sticky,
`endif
  output logic [WIDTH-1:0] o_data,
  output logic             o_tc,
  output logic             o_ovf
);

  if (WIDTH < 1) begin : g_err_width
    $fatal(1, "counter_param: WIDTH must be >= 1");
  end
  if (MAX_VAL < 1) begin : g_err_max_lo
    $fatal(1, "counter_param: MAX_VAL must be >= 1");
  end
  if ((WIDTH < 32) && (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1))) begin : g_err_max_hi
    $fatal(1, "counter_param: MAX_VAL does not fit in WIDTH bits");
  end
  if (RST_VAL > MAX_VAL) begin : g_err_rst
    $fatal(1, "counter_param: RST_VAL exceeds MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RstV = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] OneV = WIDTH'(1);
  localparam bit               Sat  = (SATURATE != 0);

  logic [WIDTH-1:0] r_data;
  logic             r_ovf;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_ovf_nxt;
  logic             w_at_max;
  logic             w_at_min;

  assign w_at_max = (r_data == MaxV);
  assign w_at_min = (r_data == '0);

  always_comb begin
    w_data_nxt = r_data;
    w_ovf_nxt  = 1'b0;
    if (i_load) begin
      w_data_nxt = (i_load_data > MaxV) ? MaxV : i_load_data;
    end else if (i_ce) begin
      if (i_up) begin
        if (w_at_max) begin
          w_ovf_nxt  = 1'b1;
          w_data_nxt = Sat ? MaxV : '0;
        end else begin
          w_data_nxt = r_data + OneV;
        end
      end else begin
        if (w_at_min) begin
          w_ovf_nxt  = 1'b1;
          w_data_nxt = Sat ? '0 : MaxV;
        end else begin
          w_data_nxt = r_data - OneV;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= RstV;
      r_ovf  <= 1'b0;
    end else begin
      r_data <= w_data_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

`ifdef COUNTER_OVF_STICKY_EN
  logic r_ovf_sticky;

  // A new overflow on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf_sticky <= 1'b0;
    end else begin
      r_ovf_sticky <= w_ovf_nxt | (r_ovf_sticky & ~i_ovf_clr);
    end
  end

  assign o_ovf_sticky = r_ovf_sticky;
`endif

  assign o_data = r_data;
  assign o_ovf  = r_ovf;
  assign o_tc   = i_up ? w_at_max : w_at_min;

endmodule

// File: tb/tb_counter_param.sv
// Directed bench: a wrapping and a saturating counter_param (WIDTH=4, MAX_VAL=9) on shared inputs.
// Sticky-flag checks are built only when COUNTER_OVF_STICKY_EN is defined.
module tb_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       up;
  logic       load;
  logic [3:0] load_data;
`ifdef COUNTER_OVF_STICKY_EN
  logic       ovf_clr;
  logic       w_sticky;
  logic       s_sticky;
`endif
  logic [3:0] w_data;
  logic       w_tc;
  logic       w_ovf;
  logic [3:0] s_data;
  logic       s_tc;
  logic       s_ovf;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  counter_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0), .SATURATE(0)) u_wrap (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ce        (ce),
    .i_up        (up),
    .i_load      (load),
    .i_load_data (load_data),
`ifdef COUNTER_OVF_STICKY_EN
    .i_ovf_clr   (ovf_clr),
    .o_ovf_sticky(w_sticky),
`endif
    .o_data      (w_data),
    .o_tc        (w_tc),
    .o_ovf       (w_ovf)
  );

  counter_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0), .SATURATE(1)) u_sat (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ce        (ce),
    .i_up        (up),
    .i_load      (load),
    .i_load_data (load_data),
`ifdef COUNTER_OVF_STICKY_EN
    .i_ovf_clr   (ovf_clr),
    .o_ovf_sticky(s_sticky),
`endif
    .o_data      (s_data),
    .o_tc        (s_tc),
    .o_ovf       (s_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    ce        = 1'b0;
    up        = 1'b0;
    load      = 1'b0;
    load_data = 4'd0;
`ifdef COUNTER_OVF_STICKY_EN
    ovf_clr   = 1'b0;
`endif
    // Reset is asynchronous: values must be there before the first clock edge.
    #2;
    check("rst_data", w_data, 0);
    check("rst_ovf", w_ovf, 0);
    check("rst_tc_down", w_tc, 1);
`ifdef COUNTER_OVF_STICKY_EN
    check("rst_sticky", w_sticky, 0);
`endif
    step();
    check("rst_hold_edge", w_data, 0);

    // 1: count down from 0 with wrap
    rst = 1'b0;
    ce  = 1'b1;
    up  = 1'b0;
    #1;
    check("t1_tc_at0", w_tc, 1);
    step();
    check("t1_e1_data", w_data, 9);
    check("t1_e1_ovf", w_ovf, 1);
    check("t1_e1_tc", w_tc, 0);
`ifdef COUNTER_OVF_STICKY_EN
    check("t1_sticky_set", w_sticky, 1);
`endif
    step();
    check("t1_e2_data", w_data, 8);
    check("t1_e2_ovf", w_ovf, 0);
    step();
    check("t1_e3_data", w_data, 7);
    check("t1_e3_ovf", w_ovf, 0);

    // 2: from 0 count up 10 edges, wrap on the 10th
    load      = 1'b1;
    load_data = 4'd0;
    step();
    check("t2_load0", w_data, 0);
    load = 1'b0;
    up   = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("t2_data_%0d", i), w_data, (i == 10) ? 0 : i);
      check($sformatf("t2_ovf_%0d", i), w_ovf, (i == 10) ? 1 : 0);
      check($sformatf("t2_tc_%0d", i), w_tc, (i == 9) ? 1 : 0);
    end

    // 3: saturating instance at the top bound
    load      = 1'b1;
    load_data = 4'd9;
    step();
    check("t3_load9", s_data, 9);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("t3_sat_data_%0d", i), s_data, 9);
      check($sformatf("t3_sat_ovf_%0d", i), s_ovf, 1);
      check($sformatf("t3_sat_tc_%0d", i), s_tc, 1);
    end
    up = 1'b0;
    step();
    check("t3_down_data", s_data, 8);
    check("t3_down_ovf", s_ovf, 0);

    // 4: load clamps, takes priority over ce
    up        = 1'b1;
    load      = 1'b1;
    load_data = 4'd12;
    step();
    check("t4_clamp_data", w_data, 9);
    check("t4_clamp_ovf", w_ovf, 0);
    load_data = 4'd5;
    step();
    check("t4_load5", w_data, 5);
    load = 1'b0;
    step();
    check("t4_count6", w_data, 6);

    // 5: async reset mid-count, between edges
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_data", w_data, 0);
    check("t5_rst_ovf", w_ovf, 0);
    #1;
    rst = 1'b0;
    step();
    check("t5_resume", w_data, 1);

    // 6: wrap with clear on the same edge, then hold and clear alone
    load      = 1'b1;
    load_data = 4'd9;
    step();
    load = 1'b0;
`ifdef COUNTER_OVF_STICKY_EN
    check("t6_sticky_after_rst", w_sticky, 0);
    ovf_clr = 1'b1;
`endif
    step();
    check("t6_wrap_data", w_data, 0);
    check("t6_wrap_ovf", w_ovf, 1);
`ifdef COUNTER_OVF_STICKY_EN
    check("t6_set_wins", w_sticky, 1);
`endif
    ce = 1'b0;
    step();
    check("t6_hold_data", w_data, 0);
    check("t6_hold_ovf", w_ovf, 0);
`ifdef COUNTER_OVF_STICKY_EN
    check("t6_cleared", w_sticky, 0);
    ovf_clr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
